rr_grant_sequencer16: RTL and testbench
=======================================

Name: rr_grant_sequencer16

Overview:
- 16-way round-robin arbiter. It shares one resource among 16 requesters.
- Issues a single registered one-hot grant (4-to-16 decoded from the winning index) plus the encoded index.
- Sits in front of the shared resource select path. The downstream 4-bit select decoder is driven from grant_idx.
- A grant is held until the owner signals done, drops its request, or the optional hold limit expires.

Parameters:
- MAX_HOLD, 0, maximum cycles a grant is held. 0 = unlimited. Legal range 0..255.
- CNT_W, 8, width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  16  request vector. Bit i = requester i.
- done  input  1  owner releases the resource. Sampled only in BUSY.
- grant  output  16  registered one-hot grant. All zero when no grant.
- grant_idx  output  4  index of the current or most recent winner.
- grant_valid  output  1  high while a grant is active.
- busy_cycles  output  CNT_W  cycles the current grant has been held. 0 in IDLE.

Behaviour:
- Reset (async assert, sync-safe release):
  - State = IDLE; grant = 16'h0000; grant_valid = 0; grant_idx = 4'h0; busy_cycles = 0.
  - Internal last-winner pointer = 4'hF, so the first search starts at requester 0.
- State machine has two states: IDLE and BUSY.
- IDLE:
  - grant_valid = 0, grant = 0.
  - If req != 0 at a rising edge: winner = first set bit scanning upward from (last+1) mod 16, wrapping past 15 to 0.
  - At that same edge: grant_idx <= winner; grant <= one-hot(winner); grant_valid <= 1; busy_cycles <= 0; state -> BUSY.
  - Latency: req high before edge N produces grant visible after edge N (1 cycle).
  - done is ignored in IDLE.
- BUSY: a release condition is evaluated each edge. Release if any of the following holds:
  - done == 1;
  - req[grant_idx] == 0;
  - MAX_HOLD != 0 and busy_cycles == MAX_HOLD-1.
- On release:
  - grant <= 0; grant_valid <= 0; busy_cycles <= 0; last <= grant_idx; state -> IDLE.
  - grant_idx keeps the old value (sticky).
- Without release: busy_cycles <= busy_cycles + 1, saturating at all-ones. grant and grant_idx are stable.
- One mandatory dead cycle (IDLE) between consecutive grants. No back-to-back grants, even to different requesters.
- Fairness:
  - After requester k is released, k has the lowest priority in the next search.
  - A sole remaining requester k is re-granted after the dead cycle.
- Simultaneous events:
  - done together with req drop or timeout counts as a single release; no double action.
  - Changes to req bits other than grant_idx during BUSY have no effect.
- Invariants:
  - grant is always zero or exactly one-hot.
  - grant == one-hot(grant_idx) whenever grant_valid = 1.
  - grant_valid == (grant != 0).
- Reset mid-BUSY: outputs clear immediately (asynchronously). The pointer returns to 4'hF, so priority restarts at 0.
- Width rules:
  - Pointer arithmetic is modulo 16; natural 4-bit wrap.
  - MAX_HOLD = 1 limits every grant to exactly 1 cycle.

Test Plan:
- Reset then req = 16'h0001 → grant = 16'h0001, grant_idx = 0, grant_valid = 1 one cycle after the sampling edge; busy_cycles = 0.
- req = 16'hFFFF held, done pulsed each BUSY cycle → grant_idx sequence 0,1,2,…,15,0 with a one-cycle grant_valid = 0 gap between grants.
- req = 16'h8001 after 15 was last winner → grant_idx = 0; after release, grant_idx = 15; then 0 again. Verifies wrap.
- MAX_HOLD = 4, req = 16'h0010 held, no done → grant valid exactly 4 cycles (busy_cycles 0..3), 1 idle cycle, re-grant to 4.
- Owner drops req[5] mid-grant with done = 0 → grant clears next edge, last = 5; a pending req[3] is granted after the dead cycle.
- rst_n asserted while BUSY with grant_idx = 9 → grant = 0, grant_valid = 0 immediately; after release with req = 16'h0600, grant_idx = 9.

Source files
------------

// File: rtl/rr_grant_sequencer16.sv
// ---------------------------------------------------------------------------
// rr_grant_sequencer16
//
// 16-way round-robin arbiter. It shares one downstream resource among 16
// requesters. It issues one registered one-hot grant and the encoded winner
// index, which drives the downstream 4-bit select decoder. A grant is held
// until one of these happens: the owner asserts done, the owner drops its
// request, or the optional hold limit runs out. A released grant is always
// followed by one idle cycle before the next grant.
//
// Parameters
//   MAX_HOLD  maximum cycles a grant is held, 0 = unlimited (0..255)
//   CNT_W     hold counter width, 2**CNT_W must exceed MAX_HOLD
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   req_i[15:0]    request vector, bit i = requester i
//   done_i         owner releases the resource (only looked at while busy)
//   grant_o[15:0]  registered one-hot grant, zero when nothing is granted
//   grant_idx_o    index of the current or most recent winner (sticky)
//   grant_valid_o  high while a grant is active
//   busy_cycles_o  cycles the current grant has been held, zero when idle
// ---------------------------------------------------------------------------
module rr_grant_sequencer16 #(
    parameter int MAX_HOLD = 0,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      req_i,
    input  logic             done_i,
    output logic [15:0]      grant_o,
    output logic [3:0]       grant_idx_o,
    output logic             grant_valid_o,
    output logic [CNT_W-1:0] busy_cycles_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [15:0]      grant_q, grant_d;
    logic [3:0]       idx_q, idx_d;
    logic [3:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [15:0]      upper_mask;
    logic [15:0]      req_upper;
    logic [15:0]      winner_onehot;
    logic [3:0]       winner_idx;
    logic             hold_expired;
    logic             release_now;

    // Returns the index of the lowest set bit. It returns 0 when no bit is
    // set. The caller only uses the result when some request is present.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] r;
        r = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                r = 4'(i);
            end
        end
        return r;
    endfunction

    // Round-robin search without a rotator. Requesters above the last winner
    // get first pick. If none of them is requesting, the search wraps to the
    // lowest requester overall. When last is 15 the upper mask is empty, so
    // the search naturally starts at requester 0.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_sel
            assign upper_mask[gi]    = (4'(gi) > last_q);
            assign winner_onehot[gi] = (winner_idx == 4'(gi));
        end
    endgenerate

    assign req_upper  = req_i & upper_mask;
    assign winner_idx = (req_upper != 16'h0000) ? lowest_set(req_upper)
                                                : lowest_set(req_i);

    // The hold limit fires on the last allowed cycle. This keeps the grant
    // visible for exactly MAX_HOLD cycles (busy_cycles 0..MAX_HOLD-1).
    generate
        if (MAX_HOLD == 0) begin : g_no_limit
            assign hold_expired = 1'b0;
        end else begin : g_limit
            assign hold_expired = (cnt_q == CNT_W'(MAX_HOLD - 1));
        end
    endgenerate

    // All release causes merge into one condition. Coincident causes
    // therefore produce a single release.
    assign release_now = done_i | ~req_i[idx_q] | hold_expired;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i != 16'h0000) begin
                    state_d = ST_BUSY;
                    grant_d = winner_onehot;
                    idx_d   = winner_idx;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                if (release_now) begin
                    // grant_idx stays sticky. The released owner becomes
                    // the lowest-priority requester for the next search.
                    state_d = ST_IDLE;
                    grant_d = 16'h0000;
                    cnt_d   = '0;
                    last_d  = idx_q;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 16'h0000;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= 16'h0000;
            idx_q   <= 4'h0;
            last_q  <= 4'hF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_idx_o   = idx_q;
    assign grant_valid_o = (state_q == ST_BUSY);
    assign busy_cycles_o = cnt_q;

endmodule

// File: tb/tb_rr_grant_sequencer16.sv
// ---------------------------------------------------------------------------
// Bench for rr_grant_sequencer16. Three instances share one stimulus stream:
// unlimited hold, a hold limit of 4, and a hold limit of 1. A behavioural
// model of each instance is checked on every falling edge. Directed
// literal checks pin the model at the key points of each scenario.
// ---------------------------------------------------------------------------
module tb_rr_grant_sequencer16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req = 16'h0000;
    logic        done = 1'b0;

    logic [15:0] g0, g4, g1;
    logic [3:0]  i0, i4, i1;
    logic        v0, v4, v1;
    logic [7:0]  c0, c4, c1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_grant_sequencer16 #(.MAX_HOLD(0), .CNT_W(8)) u_h0 (
        .clk(clk), .rst_n(rst_n), .req_i(req), .done_i(done),
        .grant_o(g0), .grant_idx_o(i0), .grant_valid_o(v0), .busy_cycles_o(c0));
    rr_grant_sequencer16 #(.MAX_HOLD(4), .CNT_W(8)) u_h4 (
        .clk(clk), .rst_n(rst_n), .req_i(req), .done_i(done),
        .grant_o(g4), .grant_idx_o(i4), .grant_valid_o(v4), .busy_cycles_o(c4));
    rr_grant_sequencer16 #(.MAX_HOLD(1), .CNT_W(8)) u_h1 (
        .clk(clk), .rst_n(rst_n), .req_i(req), .done_i(done),
        .grant_o(g1), .grant_idx_o(i1), .grant_valid_o(v1), .busy_cycles_o(c1));

    // ---------------- behavioural model ----------------
    int   mh [3] = '{0, 4, 1};
    logic m_busy [3];
    int   m_idx  [3];
    int   m_last [3];
    int   m_cnt  [3];

    // First requesting index found when walking upward from last+1 mod 16.
    function automatic int rr_pick(input int last, input logic [15:0] r);
        for (int off = 1; off <= 16; off++) begin
            if (r[(last + off) % 16]) return (last + off) % 16;
        end
        return 0;
    endfunction

    function automatic logic releases(input int k, input logic d, input logic [15:0] r,
                                      input int idx, input int cnt);
        return d || !r[idx] || (mh[k] != 0 && cnt == mh[k] - 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_busy[k] <= 1'b0;
                m_idx[k]  <= 0;
                m_last[k] <= 15;
                m_cnt[k]  <= 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!m_busy[k]) begin
                    if (req != 16'h0000) begin
                        m_busy[k] <= 1'b1;
                        m_idx[k]  <= rr_pick(m_last[k], req);
                        m_cnt[k]  <= 0;
                    end
                end else if (releases(k, done, req, m_idx[k], m_cnt[k])) begin
                    m_busy[k] <= 1'b0;
                    m_last[k] <= m_idx[k];
                    m_cnt[k]  <= 0;
                end else begin
                    m_cnt[k] <= (m_cnt[k] >= 255) ? 255 : m_cnt[k] + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int k, input logic [15:0] g, input logic [3:0] idx,
                            input logic v, input logic [7:0] c);
        logic [15:0] eg;
        eg = m_busy[k] ? (16'h0001 << m_idx[k]) : 16'h0000;
        chk($sformatf("model%0d.grant", k), 32'(g), 32'(eg));
        chk($sformatf("model%0d.idx", k), 32'(idx), 32'(m_idx[k]));
        chk($sformatf("model%0d.valid", k), 32'(v), 32'(m_busy[k]));
        chk($sformatf("model%0d.busy_cycles", k), 32'(c), m_busy[k] ? 32'(m_cnt[k]) : 32'd0);
    endtask

    logic v0_prev = 1'b0;
    always @(negedge clk) begin
        cmp_inst(0, g0, i0, v0, c0);
        cmp_inst(1, g4, i4, v4, c4);
        cmp_inst(2, g1, i1, v1, c1);
        if (v0 && !v0_prev) $display("grant: idx=%0d req=%04h t=%0t", i0, req, $time);
        v0_prev = v0;
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        tick(); tick();
        chk("reset.grant", 32'(g0), 32'h0);
        chk("reset.idx", 32'(i0), 32'h0);
        chk("reset.valid", 32'(v0), 32'h0);
        chk("reset.busy_cycles", 32'(c0), 32'h0);
        rst_n = 1'b1;
        tick();

        // Single requester 0: grant one cycle after the sampling edge.
        req = 16'h0001;
        tick();
        chk("first.grant", 32'(g0), 32'h0001);
        chk("first.idx", 32'(i0), 32'h0);
        chk("first.valid", 32'(v0), 32'h1);
        chk("first.busy_cycles", 32'(c0), 32'h0);
        req = 16'h0000;
        tick();
        chk("drop.valid", 32'(v0), 32'h0);
        chk("drop.idx_sticky", 32'(i0), 32'h0);

        // Restart from reset, all requesting, done held high: 0..15 with gaps.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        req = 16'hFFFF; done = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("seq%0d.idx", i), 32'(i0), 32'(i));
            chk($sformatf("seq%0d.valid", i), 32'(v0), 32'h1);
            tick();
            chk($sformatf("seq%0d.gap", i), 32'(v0), 32'h0);
        end

        // 15 was last: 16'h8001 grants 0, then 15, then 0 again.
        req = 16'h8001;
        tick(); chk("wrap.a", 32'(i0), 32'h0);
        tick(); chk("wrap.gap1", 32'(v0), 32'h0);
        tick(); chk("wrap.b", 32'(i0), 32'hF);
        tick(); chk("wrap.gap2", 32'(v0), 32'h0);
        tick(); chk("wrap.c", 32'(i0), 32'h0);
        done = 1'b0; req = 16'h0000;
        tick(); tick();

        // Hold limit 4 on requester 4.
        req = 16'h0010;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("hold4.valid%0d", c), 32'(v4), 32'h1);
            chk($sformatf("hold4.cnt%0d", c), 32'(c4), 32'(c));
            chk($sformatf("hold4.idx%0d", c), 32'(i4), 32'h4);
        end
        tick(); chk("hold4.gap", 32'(v4), 32'h0);
        tick(); chk("hold4.regrant", 32'(g4), 32'h0010);
        chk("hold4.regrant_cnt", 32'(c4), 32'h0);
        chk("hold0.still_held", 32'(c0), 32'h5);
        req = 16'h0000;
        tick(); tick();

        // Owner 5 drops its request; pending 3 granted after the dead cycle.
        req = 16'h0028;
        tick(); chk("drop5.idx", 32'(i0), 32'h5);
        req = 16'h0008;
        tick(); chk("drop5.released", 32'(v0), 32'h0);
        chk("drop5.sticky", 32'(i0), 32'h5);
        tick(); chk("drop5.next", 32'(g0), 32'h0008);
        req = 16'h0000;
        tick(); tick();

        // Reset while busy on 9: outputs clear at once, priority restarts at 0.
        req = 16'h0200;
        tick(); chk("rst9.idx", 32'(i0), 32'h9);
        req = 16'h0600;
        #2 rst_n = 1'b0;
        #1;
        chk("rst9.grant_async", 32'(g0), 32'h0);
        chk("rst9.valid_async", 32'(v0), 32'h0);
        tick(); rst_n = 1'b1;
        tick(); chk("rst9.regrant", 32'(i0), 32'h9);
        chk("rst9.regrant_grant", 32'(g0), 32'h0200);
        req = 16'h0000;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
